// File: rtl/display_scan_mux.sv
// Scans a latched 4-digit hex value onto a shared digit bus with active-low anode selects.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always shows).
module display_scan_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int DIV_WIDTH   = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic        display_en,
    output logic [3:0]  digit_out,
    output logic        digit_blank,
    output logic [3:0]  an_n,
    output logic        frame_start
);

    localparam logic [DIV_WIDTH-1:0] PRESC_MAX = DIV_WIDTH'(REFRESH_DIV - 1);

    logic [DIV_WIDTH-1:0] presc;
    logic [1:0]           idx;
    logic [15:0]          shadow;
    logic                 active;
    logic                 tick;
    logic                 blank_lz;
    logic                 vis;

    assign tick = (presc == PRESC_MAX);

    // Free-running slot prescaler, independent of display_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + DIV_WIDTH'(1);
        end
    end

    // The value is latched only at frame boundaries so a frame never mixes two values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx         <= 2'd0;
            shadow      <= 16'h0000;
            active      <= 1'b0;
            frame_start <= 1'b0;
        end else if (tick) begin
            if (!active || idx == 2'd3) begin
                active      <= 1'b1;
                idx         <= 2'd0;
                shadow      <= value_in;
                frame_start <= 1'b1;
            end else begin
                idx         <= idx + 2'd1;
                frame_start <= 1'b0;
            end
        end else begin
            frame_start <= 1'b0;
        end
    end

    always_comb begin
        digit_out = 4'h0;
        case (idx)
            2'd0: digit_out = shadow[3:0];
            2'd1: digit_out = shadow[7:4];
            2'd2: digit_out = shadow[11:8];
            2'd3: digit_out = shadow[15:12];
            default: digit_out = 4'h0;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        blank_lz = 1'b0;
        case (idx)
            2'd1: blank_lz = (shadow[15:4] == 12'h000);
            2'd2: blank_lz = (shadow[15:8] == 8'h00);
            2'd3: blank_lz = (shadow[15:12] == 4'h0);
            default: blank_lz = 1'b0;
        endcase
    end
`else
    assign blank_lz = 1'b0;
`endif

    assign vis         = active && display_en && !blank_lz;
    assign an_n        = vis ? ~(4'b0001 << idx) : 4'b1111;
    assign digit_blank = !vis;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with REFRESH_DIV=4; expectations adapt to LEADING_ZERO_BLANK_EN.
module tb_display_scan_mux;

    logic        clk;
    logic        reset;
    logic [15:0] value_in;
    logic        display_en;
    logic [3:0]  digit_out;
    logic        digit_blank;
    logic [3:0]  an_n;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    display_scan_mux #(
        .REFRESH_DIV(4),
        .DIV_WIDTH  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value_in   (value_in),
        .display_en (display_en),
        .digit_out  (digit_out),
        .digit_blank(digit_blank),
        .an_n       (an_n),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample on the falling edge.
    task automatic applyStimulus();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkDark(input string tag);
        checkOutput({tag, "_an"}, {12'h0, an_n}, 16'h000F);
        checkOutput({tag, "_blank"}, {15'h0, digit_blank}, 16'h0001);
        checkOutput({tag, "_fs"}, {15'h0, frame_start}, 16'h0000);
    endtask

    // One full slot: expected anode pattern and nibble, with frame_start expected only on its first cycle.
    task automatic runSlot(input string tag, input logic [3:0] expAn, input logic [3:0] expDigit,
                           input logic expFs);
        for (int c = 0; c < 4; c++) begin
            applyStimulus();
            checkOutput({tag, "_an"}, {12'h0, an_n}, {12'h0, expAn});
            checkOutput({tag, "_digit"}, {12'h0, digit_out}, {12'h0, expDigit});
            checkOutput({tag, "_blank"}, {15'h0, digit_blank}, {15'h0, (expAn == 4'hF)});
            checkOutput({tag, "_fs"}, {15'h0, frame_start}, {15'h0, (c == 0) ? expFs : 1'b0});
        end
    endtask

    task automatic releaseReset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            checkDark(tag);
        end
    endtask

    initial begin
        reset      = 1'b1;
        value_in   = 16'h1234;
        display_en = 1'b1;

        repeat (3) @(negedge clk);
        checkDark("rst_held");
        checkOutput("rst_digit", {12'h0, digit_out}, 16'h0000);

        releaseReset("startup");
        runSlot("f1_d0", 4'b1110, 4'h4, 1'b1);
        runSlot("f1_d1", 4'b1101, 4'h3, 1'b0);
        runSlot("f1_d2", 4'b1011, 4'h2, 1'b0);
        runSlot("f1_d3", 4'b0111, 4'h1, 1'b0);

        runSlot("f2_d0", 4'b1110, 4'h4, 1'b1);
        runSlot("f2_d1", 4'b1101, 4'h3, 1'b0);
        value_in = 16'hABCD;
        runSlot("f2_d2", 4'b1011, 4'h2, 1'b0);
        runSlot("f2_d3", 4'b0111, 4'h1, 1'b0);
        runSlot("f3_d0", 4'b1110, 4'hD, 1'b1);
        runSlot("f3_d1", 4'b1101, 4'hC, 1'b0);
        runSlot("f3_d2", 4'b1011, 4'hB, 1'b0);
        runSlot("f3_d3", 4'b0111, 4'hA, 1'b0);

        runSlot("f4_d0", 4'b1110, 4'hD, 1'b1);
        applyStimulus();
        checkOutput("en_pre_an", {12'h0, an_n}, 16'h000D);
        display_en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus();
            checkDark("en_off");
            checkOutput("en_off_digit", {12'h0, digit_out}, (c < 3) ? 16'h000C : 16'h000B);
        end
        display_en = 1'b1;
        applyStimulus();
        checkOutput("en_back_an", {12'h0, an_n}, 16'h000B);
        checkOutput("en_back_digit", {12'h0, digit_out}, 16'h000B);
        checkOutput("en_back_blank", {15'h0, digit_blank}, 16'h0000);
        runSlot("f4_d3", 4'b0111, 4'hA, 1'b0);

        applyStimulus();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkDark("async_rst");
        applyStimulus();
        releaseReset("after_rst");
        runSlot("r_d0", 4'b1110, 4'hD, 1'b1);
        runSlot("r_d1", 4'b1101, 4'hC, 1'b0);

        @(negedge clk);
        reset    = 1'b1;
        value_in = 16'h0050;
        @(negedge clk);
        checkDark("lz_rst");
        releaseReset("lz_start");
        runSlot("lz50_d0", 4'b1110, 4'h0, 1'b1);
        value_in = 16'h0000;
        runSlot("lz50_d1", 4'b1101, 4'h5, 1'b0);
        runSlot("lz50_d2", LZ ? 4'b1111 : 4'b1011, 4'h0, 1'b0);
        runSlot("lz50_d3", LZ ? 4'b1111 : 4'b0111, 4'h0, 1'b0);
        runSlot("lz00_d0", 4'b1110, 4'h0, 1'b1);
        runSlot("lz00_d1", LZ ? 4'b1111 : 4'b1101, 4'h0, 1'b0);
        runSlot("lz00_d2", LZ ? 4'b1111 : 4'b1011, 4'h0, 1'b0);
        runSlot("lz00_d3", LZ ? 4'b1111 : 4'b0111, 4'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
